// File: rtl/ifu_fetch_if.sv
// -----------------------------------------------------------------------------
// ifu_fetch_if
//
// Bundles every bus between the instruction fetch unit and its neighbours:
//   - memory read-address channel  : araddr, arvalid, arready
//   - memory read-data channel     : rdata, rresp, rvalid, rready
//   - decoder channel              : inst, inst_pc, inst_valid, inst_ready
//   - commit stage next-PC return  : commit_valid, commit_pc
//   - status                       : fault, fault_cause, fault_pc, fetch_cnt
//
// Modports:
//   master - the fetch unit itself (drives requests, decoder data and status)
//   slave  - the environment (memory, decoder and commit stage)
// -----------------------------------------------------------------------------
interface ifu_fetch_if;

    // Memory read-address channel
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;

    // Memory read-data channel
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    // Decoder channel
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    // Next PC from the commit stage
    logic        commit_valid;
    logic [31:0] commit_pc;

    // Status
    logic        fault;
    logic        fault_cause;
    logic [31:0] fault_pc;
    logic [31:0] fetch_cnt;

    modport master (
        output araddr, arvalid, rready,
        output inst, inst_pc, inst_valid,
        output fault, fault_cause, fault_pc, fetch_cnt,
        input  arready, rdata, rresp, rvalid,
        input  inst_ready, commit_valid, commit_pc
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  inst, inst_pc, inst_valid,
        input  fault, fault_cause, fault_pc, fetch_cnt,
        output arready, rdata, rresp, rvalid,
        output inst_ready, commit_valid, commit_pc
    );

endinterface : ifu_fetch_if

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
//
// Instruction fetch unit of the multi-cycle NPC core. Holds the architectural
// PC and walks one instruction at a time through:
//   IDLE -> AR (address request) -> R (data beat) -> OUT (hand to decoder)
//        -> WAITPC (wait for commit to return the next PC) -> AR ...
// A non-OKAY read response or a misaligned next PC parks the unit in FAULT,
// which only reset leaves.
//
// Parameters:
//   RESET_PC - PC loaded on reset; must be word-aligned.
//
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - ifu_fetch_if.master: memory read channel, decoder channel,
//          commit next-PC input and fault/status outputs
//
// The handshake outputs (arvalid, rready, inst_valid) are decoded from the
// state register alone; every other output is a register, so no input has a
// combinational path to any output.
// -----------------------------------------------------------------------------
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_OUT,
        S_WAITPC,
        S_FAULT
    } state_t;

    state_t state_q;
    state_t state_d;

    // Architectural and output registers
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        fault_q;
    logic        fault_cause_q;
    logic [31:0] fault_pc_q;
    logic [31:0] fetch_cnt_q;

    // Handshake qualifiers: an input only counts in the state that listens
    // to it, so stray arready/rvalid/commit_valid elsewhere are ignored.
    logic r_fire;
    logic r_ok;
    logic out_fire;
    logic commit_fire;
    logic commit_misaligned;

    always_comb begin
        r_fire            = (state_q == S_R)      && bus.rvalid;
        r_ok              = (bus.rresp == 2'b00);
        out_fire          = (state_q == S_OUT)    && bus.inst_ready;
        commit_fire       = (state_q == S_WAITPC) && bus.commit_valid;
        commit_misaligned = (bus.commit_pc[1:0] != 2'b00);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so that
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_d takes its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_AR;
            end
            S_AR: begin
                // rvalid arriving alongside arready belongs to nobody yet;
                // only the address handshake is taken here.
                if (bus.arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (bus.rvalid) begin
                    state_d = r_ok ? S_OUT : S_FAULT;
                end
            end
            S_OUT: begin
                // A commit_valid seen here is dropped; commit has to present
                // the next PC again once we sit in WAITPC.
                if (bus.inst_ready) begin
                    state_d = S_WAITPC;
                end
            end
            S_WAITPC: begin
                if (bus.commit_valid) begin
                    state_d = commit_misaligned ? S_FAULT : S_AR;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // PC and captured instruction
    // -------------------------------------------------------------------------
    // inst/inst_pc are deliberately not cleared when leaving OUT; they keep
    // the last accepted instruction until the next successful beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0000_0000;
            inst_pc_q <= RESET_PC;
        end else begin
            if (r_fire && r_ok) begin
                inst_q    <= bus.rdata;
                inst_pc_q <= pc_q;
            end
            // The PC follows commit even when it is misaligned, so araddr
            // shows the offending address while parked in FAULT.
            if (commit_fire) begin
                pc_q <= bus.commit_pc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sticky fault capture
    // -------------------------------------------------------------------------
    // The two fault sources live in different states, so they can never fire
    // in the same cycle; once fault_q is set the FSM stays in FAULT and
    // neither source can fire again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q       <= 1'b0;
            fault_cause_q <= 1'b0;
            fault_pc_q    <= 32'h0000_0000;
        end else if (r_fire && !r_ok) begin
            fault_q       <= 1'b1;
            fault_cause_q <= 1'b1;
            fault_pc_q    <= pc_q;
        end else if (commit_fire && commit_misaligned) begin
            fault_q       <= 1'b1;
            fault_cause_q <= 1'b0;
            fault_pc_q    <= bus.commit_pc;
        end
    end

    // -------------------------------------------------------------------------
    // Delivered-instruction counter (free-running, wraps modulo 2^32)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0000_0000;
        end else if (out_fire) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.arvalid     = (state_q == S_AR);
    assign bus.rready      = (state_q == S_R);
    assign bus.inst_valid  = (state_q == S_OUT);
    assign bus.araddr      = pc_q;
    assign bus.inst        = inst_q;
    assign bus.inst_pc     = inst_pc_q;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = fault_cause_q;
    assign bus.fault_pc    = fault_pc_q;
    assign bus.fetch_cnt   = fetch_cnt_q;

endmodule : ifu_fetch

// File: tb/tb_ifu_fetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch
//
// Self-checking bench for ifu_fetch. The bench plays memory, decoder and
// commit stage. A small architectural model (pc, last instruction, delivered
// count, fault record) is advanced per transaction from the block's rules and
// every observation is compared against it. Inputs are driven and outputs
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          BUDGET   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;

    // What the bench saw during one fetch transaction
    typedef struct {
        bit          timeout;
        int          wait_cycles;
        logic [31:0] araddr;
        bit          ar_stable;
        bit          r_entered;
        bit          r_stable;
        bit          inst_valid_on_time;
        bit          out_stable;
        logic [31:0] inst;
        logic [31:0] inst_pc;
        logic [31:0] cnt_after;
        logic        valid_after;
    } fetch_obs_t;

    // Expected value of all status/bus outputs while in reset
    localparam logic [164:0] RESET_VEC = {1'b0, RESET_PC, 1'b0, 32'h0, RESET_PC,
                                          1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    function automatic logic [164:0] out_vec();
        return {bus.arvalid, bus.araddr, bus.rready, bus.inst, bus.inst_pc,
                bus.inst_valid, bus.fault, bus.fault_cause, bus.fault_pc, bus.fetch_cnt};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.arready      = 1'b0;
        bus.rvalid       = 1'b0;
        bus.rdata        = 32'h0;
        bus.rresp        = 2'b00;
        bus.inst_ready   = 1'b0;
        bus.commit_valid = 1'b0;
        bus.commit_pc    = 32'h0;
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_cnt     = 32'h0;
        m_inst    = 32'h0;
        m_inst_pc = RESET_PC;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] rand_aligned_pc();
        return RESET_PC + ({22'h0, 10'($urandom_range(0, 1023))} << 2);
    endfunction

    // One full fetch as memory and decoder: waits (bounded) for arvalid,
    // stalls each channel for the requested number of cycles, then completes.
    task automatic drive_fetch(input int ar_dly, input int r_dly, input int out_dly,
                               input logic [31:0] data, input logic [1:0] resp,
                               input bit junk_r, input bit commit_in_out,
                               output fetch_obs_t o);
        o = '{default: 0};
        while (bus.arvalid !== 1'b1 && o.wait_cycles < BUDGET) begin
            tick();
            o.wait_cycles++;
        end
        if (bus.arvalid !== 1'b1) begin
            o.timeout = 1'b1;
            return;
        end
        o.araddr    = bus.araddr;
        o.ar_stable = 1'b1;
        for (int i = 0; i < ar_dly; i++) begin
            tick();
            if (bus.arvalid !== 1'b1 || bus.araddr !== o.araddr || bus.rready !== 1'b0)
                o.ar_stable = 1'b0;
        end
        bus.arready = 1'b1;
        if (junk_r) begin
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hDEAD_BEEF;
            bus.rresp  = 2'b10;
        end
        tick();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h0;
        bus.rresp   = 2'b00;
        o.r_entered = (bus.rready === 1'b1 && bus.arvalid === 1'b0);
        o.r_stable  = 1'b1;
        for (int i = 0; i < r_dly; i++) begin
            tick();
            if (bus.rready !== 1'b1 || bus.inst_valid !== 1'b0) o.r_stable = 1'b0;
        end
        bus.rvalid = 1'b1;
        bus.rdata  = data;
        bus.rresp  = resp;
        tick();
        bus.rvalid = 1'b0;
        bus.rdata  = $urandom;
        bus.rresp  = 2'b00;
        o.inst_valid_on_time = (bus.inst_valid === 1'b1);
        if (resp != 2'b00) return;
        o.inst       = bus.inst;
        o.inst_pc    = bus.inst_pc;
        o.out_stable = 1'b1;
        for (int i = 0; i < out_dly; i++) begin
            if (commit_in_out) begin
                bus.commit_valid = 1'b1;
                bus.commit_pc    = rand_aligned_pc();
            end
            tick();
            bus.commit_valid = 1'b0;
            if (bus.inst_valid !== 1'b1 || bus.inst !== o.inst || bus.inst_pc !== o.inst_pc)
                o.out_stable = 1'b0;
        end
        bus.inst_ready = 1'b1;
        if (commit_in_out) begin
            bus.commit_valid = 1'b1;
            bus.commit_pc    = rand_aligned_pc();
        end
        tick();
        bus.inst_ready   = 1'b0;
        bus.commit_valid = 1'b0;
        o.cnt_after      = bus.fetch_cnt;
        o.valid_after    = bus.inst_valid;
    endtask

    // Commit stage: waits dly cycles (IFU must be silent), then returns pc.
    task automatic drive_commit(input int dly, input logic [31:0] pc, output bit quiet);
        quiet = (bus.arvalid === 1'b0 && bus.rready === 1'b0 && bus.inst_valid === 1'b0);
        for (int i = 0; i < dly; i++) begin
            tick();
            if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || bus.inst_valid !== 1'b0)
                quiet = 1'b0;
        end
        bus.commit_valid = 1'b1;
        bus.commit_pc    = pc;
        tick();
        bus.commit_valid = 1'b0;
        bus.commit_pc    = $urandom;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        fetch_obs_t o;
        drive_idle();
        rst = 1'b1;
        repeat (3) tick();
        model_reset();
        n_checks++;
        if (out_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %h, expected %h", out_vec(), RESET_VEC);
        end
        rst = 1'b0;
        n_checks++;
        if (bus.arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cycle_arvalid: got %b, expected 0", bus.arvalid);
        end
        drive_fetch(0, 0, 0, 32'h0000_0413, 2'b00, 1'b0, 1'b0, o);
        n_checks++;
        if (o.timeout || o.wait_cycles != 1) begin
            n_fail++;
            $display("FAIL first_ar_latency: got timeout=%0b cycles=%0d, expected 1 cycle",
                     o.timeout, o.wait_cycles);
        end
        if (o.timeout) return;
        n_checks++;
        if ({o.araddr, o.inst, o.inst_pc} !== {m_pc, 32'h0000_0413, m_pc}) begin
            n_fail++;
            $display("FAIL first_fetch: got araddr=%h inst=%h inst_pc=%h, expected %h %h %h",
                     o.araddr, o.inst, o.inst_pc, m_pc, 32'h0000_0413, m_pc);
        end
        n_checks++;
        if (!o.inst_valid_on_time) begin
            n_fail++;
            $display("FAIL first_latency: got inst_valid=0 in 3rd cycle after AR, expected 1");
        end
        m_cnt     = m_cnt + 32'd1;
        m_inst    = 32'h0000_0413;
        m_inst_pc = m_pc;
        n_checks++;
        if (o.cnt_after !== m_cnt || o.valid_after !== 1'b0) begin
            n_fail++;
            $display("FAIL first_count: got cnt=%h valid=%b, expected cnt=%h valid=0",
                     o.cnt_after, o.valid_after, m_cnt);
        end
    endtask

    task automatic test_backpressure();
        fetch_obs_t  o;
        bit          quiet;
        logic [31:0] data;
        m_pc = m_pc + 32'd4;
        drive_commit(2, m_pc, quiet);
        n_checks++;
        if (!quiet || bus.arvalid !== 1'b1 || bus.araddr !== m_pc) begin
            n_fail++;
            $display("FAIL bp_commit: got quiet=%b arvalid=%b araddr=%h, expected 1 1 %h",
                     quiet, bus.arvalid, bus.araddr, m_pc);
        end
        data = $urandom;
        drive_fetch(4, 3, 5, data, 2'b00, 1'b0, 1'b0, o);
        n_checks++;
        if (o.timeout || !o.ar_stable || !o.r_entered || !o.r_stable || !o.out_stable) begin
            n_fail++;
            $display("FAIL bp_stable: got timeout=%b ar=%b r_in=%b r=%b out=%b, expected 0 1 1 1 1",
                     o.timeout, o.ar_stable, o.r_entered, o.r_stable, o.out_stable);
        end
        m_cnt     = m_cnt + 32'd1;
        m_inst    = data;
        m_inst_pc = m_pc;
        n_checks++;
        if ({o.inst, o.inst_pc, o.cnt_after} !== {m_inst, m_inst_pc, m_cnt}) begin
            n_fail++;
            $display("FAIL bp_result: got inst=%h pc=%h cnt=%h, expected %h %h %h",
                     o.inst, o.inst_pc, o.cnt_after, m_inst, m_inst_pc, m_cnt);
        end
    endtask

    task automatic test_redirect();
        fetch_obs_t  o;
        bit          quiet;
        bit          stayed;
        logic [31:0] data;
        m_pc = 32'h8000_0100;
        drive_commit(1, m_pc, quiet);
        data = $urandom;
        // rvalid with a poisoned error beat alongside arready must be ignored
        drive_fetch(0, 1, 2, data, 2'b00, 1'b1, 1'b1, o);
        n_checks++;
        if (o.timeout || o.araddr !== 32'h8000_0100) begin
            n_fail++;
            $display("FAIL redirect_addr: got timeout=%b araddr=%h, expected %h",
                     o.timeout, o.araddr, 32'h8000_0100);
        end
        m_cnt     = m_cnt + 32'd1;
        m_inst    = data;
        m_inst_pc = m_pc;
        n_checks++;
        if ({o.inst, o.inst_pc, o.cnt_after, bus.fault} !== {m_inst, m_inst_pc, m_cnt, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect_junk_r: got inst=%h pc=%h cnt=%h fault=%b, expected %h %h %h 0",
                     o.inst, o.inst_pc, o.cnt_after, bus.fault, m_inst, m_inst_pc, m_cnt);
        end
        stayed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.arvalid !== 1'b0 || bus.araddr !== m_pc) stayed = 1'b0;
            tick();
        end
        n_checks++;
        if (!stayed) begin
            n_fail++;
            $display("FAIL commit_in_out_ignored: got left WAITPC, expected to stay (araddr=%h)",
                     bus.araddr);
        end
    endtask

    task automatic test_random();
        fetch_obs_t  o;
        bit          quiet;
        logic [31:0] data;
        for (int it = 0; it < 16; it++) begin
            m_pc = rand_aligned_pc();
            drive_commit($urandom_range(0, 3), m_pc, quiet);
            n_checks++;
            if (!quiet || bus.arvalid !== 1'b1 || bus.araddr !== m_pc) begin
                n_fail++;
                $display("FAIL rnd_commit[%0d]: got quiet=%b arvalid=%b araddr=%h, expected 1 1 %h",
                         it, quiet, bus.arvalid, bus.araddr, m_pc);
            end
            data = $urandom;
            drive_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        data, 2'b00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
            m_cnt     = m_cnt + 32'd1;
            m_inst    = data;
            m_inst_pc = m_pc;
            n_checks++;
            if (o.timeout || !o.ar_stable || !o.r_entered || !o.r_stable || !o.out_stable
                || !o.inst_valid_on_time) begin
                n_fail++;
                $display("FAIL rnd_handshake[%0d]: got timeout=%b ar=%b r_in=%b r=%b out=%b ontime=%b",
                         it, o.timeout, o.ar_stable, o.r_entered, o.r_stable, o.out_stable,
                         o.inst_valid_on_time);
            end
            n_checks++;
            if ({o.inst, o.inst_pc} !== {m_inst, m_inst_pc}) begin
                n_fail++;
                $display("FAIL rnd_inst[%0d]: got inst=%h pc=%h, expected %h %h",
                         it, o.inst, o.inst_pc, m_inst, m_inst_pc);
            end
            n_checks++;
            if (o.cnt_after !== m_cnt || o.valid_after !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_count[%0d]: got cnt=%h valid=%b, expected %h 0",
                         it, o.cnt_after, o.valid_after, m_cnt);
            end
        end
    endtask

    // Random input noise while parked in FAULT; nothing may wake the unit.
    task automatic check_parked(input string name, input int cycles);
        bit silent = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            bus.arready      = 1'($urandom_range(0, 1));
            bus.rvalid       = 1'($urandom_range(0, 1));
            bus.rdata        = $urandom;
            bus.inst_ready   = 1'($urandom_range(0, 1));
            bus.commit_valid = 1'($urandom_range(0, 1));
            bus.commit_pc    = rand_aligned_pc();
            tick();
            if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || bus.inst_valid !== 1'b0
                || bus.fault !== 1'b1) silent = 1'b0;
        end
        drive_idle();
        n_checks++;
        if (!silent) begin
            n_fail++;
            $display("FAIL %s: got activity or fault drop while parked, expected silence", name);
        end
    endtask

    task automatic test_bus_error();
        fetch_obs_t  o;
        bit          quiet;
        logic [1:0]  resp;
        m_pc = rand_aligned_pc();
        drive_commit(0, m_pc, quiet);
        resp = 2'($urandom_range(1, 3));
        drive_fetch(1, 1, 0, $urandom, resp, 1'b0, 1'b0, o);
        n_checks++;
        if (o.timeout || o.inst_valid_on_time) begin
            n_fail++;
            $display("FAIL buserr_inst_valid: got timeout=%b inst_valid=%b, expected 0 0",
                     o.timeout, o.inst_valid_on_time);
        end
        n_checks++;
        if ({bus.fault, bus.fault_cause, bus.fault_pc} !== {1'b1, 1'b1, m_pc}) begin
            n_fail++;
            $display("FAIL buserr_fault: got fault=%b cause=%b pc=%h, expected 1 1 %h",
                     bus.fault, bus.fault_cause, bus.fault_pc, m_pc);
        end
        n_checks++;
        if ({bus.inst, bus.inst_pc, bus.fetch_cnt} !== {m_inst, m_inst_pc, m_cnt}) begin
            n_fail++;
            $display("FAIL buserr_retain: got inst=%h pc=%h cnt=%h, expected %h %h %h",
                     bus.inst, bus.inst_pc, bus.fetch_cnt, m_inst, m_inst_pc, m_cnt);
        end
        check_parked("buserr_parked", 12);
    endtask

    task automatic test_misaligned();
        fetch_obs_t  o;
        bit          quiet;
        apply_reset();
        drive_fetch(0, 0, 0, $urandom, 2'b00, 1'b0, 1'b0, o);
        m_cnt = m_cnt + 32'd1;
        drive_commit(1, 32'h8000_0102, quiet);
        n_checks++;
        if ({bus.fault, bus.fault_cause, bus.fault_pc, bus.arvalid}
            !== {1'b1, 1'b0, 32'h8000_0102, 1'b0}) begin
            n_fail++;
            $display("FAIL misaligned_fault: got fault=%b cause=%b pc=%h arvalid=%b, expected 1 0 80000102 0",
                     bus.fault, bus.fault_cause, bus.fault_pc, bus.arvalid);
        end
        check_parked("misaligned_parked", 12);
    endtask

    task automatic test_midop_reset();
        fetch_obs_t  o;
        bit          quiet;
        int          n;
        apply_reset();
        drive_fetch(0, 0, 0, 32'h1234_5678, 2'b00, 1'b0, 1'b0, o);
        drive_commit(0, 32'h8000_0040, quiet);
        n = 0;
        while (bus.arvalid !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        n_checks++;
        if (bus.rready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_in_r: got rready=%b, expected 1", bus.rready);
        end
        // Assert reset between edges; outputs must react without a clock.
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL midop_reset_values: got %h, expected %h", out_vec(), RESET_VEC);
        end
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        drive_fetch(0, 0, 0, 32'hCAFE_0013, 2'b00, 1'b0, 1'b0, o);
        m_cnt     = m_cnt + 32'd1;
        m_inst    = 32'hCAFE_0013;
        m_inst_pc = RESET_PC;
        n_checks++;
        if (o.timeout || o.wait_cycles != 1 || o.araddr !== RESET_PC
            || {o.inst, o.inst_pc, o.cnt_after} !== {m_inst, m_inst_pc, m_cnt}) begin
            n_fail++;
            $display("FAIL midop_refetch: got cycles=%0d araddr=%h inst=%h cnt=%h, expected 1 %h %h %h",
                     o.wait_cycles, o.araddr, o.inst, o.cnt_after, RESET_PC, m_inst, m_cnt);
        end
    endtask

    task automatic test_wrap();
        fetch_obs_t  o;
        bit          quiet;
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.fetch_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        tick();
        n_checks++;
        if (bus.fetch_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL wrap_preset: got %h, expected %h", bus.fetch_cnt, m_cnt);
        end
        m_pc = rand_aligned_pc();
        drive_commit(0, m_pc, quiet);
        drive_fetch(1, 0, 1, $urandom, 2'b00, 1'b0, 1'b0, o);
        m_cnt = m_cnt + 32'd1;
        n_checks++;
        if (o.timeout || o.cnt_after !== m_cnt) begin
            n_fail++;
            $display("FAIL wrap_count: got timeout=%b cnt=%h, expected %h",
                     o.timeout, o.cnt_after, m_cnt);
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_backpressure();
        test_redirect();
        test_random();
        test_bus_error();
        test_misaligned();
        test_midop_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ifu_fetch
